// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package rr_arbiter_pkg;

  // Arbiter FSM: IDLE holds no grant, GRANT has exactly one holder.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Width of a binary index into n requesters (never less than one bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Rotating priority picker: first set request at or above ptr, wrapping.
module rr_pick
  import rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 5,
  localparam int IW = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [WIDTH-1:0] onehot,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  // Scan ptr, ptr+1, ... WIDTH-1, 0, ... ptr-1 and keep the first hit.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      int k;
      k = int'(ptr) + i;
      if (k >= WIDTH) k = k - WIDTH;
      if (!valid && req[k]) begin
        valid     = 1'b1;
        onehot[k] = 1'b1;
        idx       = IW'(k);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a hold limit. All outputs come straight from
// registers. Handshake: a requester holds its req bit high for as long as it
// wants the resource; the grant is given one cycle after the request is
// sampled and ends when the holder pulses done_i, drops its req bit, or the
// hold limit expires. At least one idle cycle separates consecutive grants.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int MAX_HOLD = 8,
  localparam int IW = idx_w(WIDTH),
  localparam int CW = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [WIDTH-1:0] req_i,
  input  logic             done_i,
  output logic [WIDTH-1:0] grant_o,
  output logic             grant_val_o,
  output logic [IW-1:0]    grant_idx_o,
  output logic             timeout_o,
  output state_t           state_o
);

  state_t           state_q, state_n;
  logic [IW-1:0]    ptr_q, ptr_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0] grant_q, grant_n;
  logic [IW-1:0]    idx_q, idx_n;
  logic             val_q, val_n;
  logic             timeout_q, timeout_n;
  logic             rel_done, rel_limit;

  logic [WIDTH-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;

  rr_pick #(.WIDTH(WIDTH)) u_pick (
    .req    (req_i),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // State, pointer, hold counter and registered outputs.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      idx_q     <= '0;
      val_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      ptr_q     <= ptr_n;
      cnt_q     <= cnt_n;
      grant_q   <= grant_n;
      idx_q     <= idx_n;
      val_q     <= val_n;
      timeout_q <= timeout_n;
    end
  end

  // Next-state logic: arbitrate in IDLE, watch for release in GRANT.
  always_comb begin
    state_n   = state_q;
    ptr_n     = ptr_q;
    cnt_n     = cnt_q;
    grant_n   = grant_q;
    idx_n     = idx_q;
    val_n     = val_q;
    timeout_n = 1'b0;
    rel_done  = 1'b0;
    rel_limit = 1'b0;
    case (state_q)
      IDLE: begin
        // done_i has no meaning without a holder, so it is not looked at.
        if (pick_valid) begin
          state_n = GRANT;
          grant_n = pick_onehot;
          idx_n   = pick_idx;
          val_n   = 1'b1;
          cnt_n   = '0;
        end else begin
          grant_n = '0;
          idx_n   = '0;
          val_n   = 1'b0;
        end
      end
      GRANT: begin
        // Only the holder's own req bit matters; others are ignored here.
        rel_done  = done_i || ((req_i & grant_q) == '0);
        // cnt_q counts completed grant cycles, so MAX_HOLD-1 marks the last.
        rel_limit = (cnt_q == CW'(MAX_HOLD - 1));
        if (rel_done || rel_limit) begin
          state_n   = IDLE;
          grant_n   = '0;
          idx_n     = '0;
          val_n     = 1'b0;
          cnt_n     = '0;
          ptr_n     = (idx_q == IW'(WIDTH - 1)) ? '0 : idx_q + IW'(1);
          timeout_n = rel_limit && !rel_done;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign grant_o     = grant_q;
  assign grant_val_o = val_q;
  assign grant_idx_o = idx_q;
  assign timeout_o   = timeout_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (WIDTH=5, MAX_HOLD=8).
module tb_rr_arbiter;
  import rr_arbiter_pkg::*;

  localparam int W  = 5;
  localparam int MH = 8;
  localparam int IW = 3;

  logic          clk_i = 1'b0;
  logic          arst_i = 1'b0;
  logic [W-1:0]  req_i = '0;
  logic          done_i = 1'b0;
  logic [W-1:0]  grant_o;
  logic          grant_val_o;
  logic [IW-1:0] grant_idx_o;
  logic          timeout_o;
  state_t        state_o;

  rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .req_i       (req_i),
    .done_i      (done_i),
    .grant_o     (grant_o),
    .grant_val_o (grant_val_o),
    .grant_idx_o (grant_idx_o),
    .timeout_o   (timeout_o),
    .state_o     (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  // holder = -1 means nobody owns the resource.
  int m_holder = -1;
  int m_ptr    = 0;
  int m_held   = 0;
  bit m_tmo    = 0;

  function automatic void model_reset();
    m_holder = -1;
    m_ptr    = 0;
    m_held   = 0;
    m_tmo    = 0;
  endfunction

  // Applies one rising edge worth of behaviour given the inputs seen before it.
  function automatic void model_edge(input logic [W-1:0] req, input logic done);
    if (m_holder < 0) begin
      m_tmo = 0;
      for (int i = 0; i < W; i++) begin
        int k;
        k = (m_ptr + i) % W;
        if (m_holder < 0 && req[k]) begin
          m_holder = k;
          m_held   = 0;
        end
      end
    end else begin
      bit by_user;
      bit by_limit;
      m_held   = m_held + 1;
      by_user  = done || !req[m_holder];
      by_limit = (m_held == MH);
      if (by_user || by_limit) begin
        m_tmo    = by_limit && !by_user;
        m_ptr    = (m_holder + 1) % W;
        m_holder = -1;
      end else begin
        m_tmo = 0;
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
  endtask

  task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
  endtask

  // Compares every output against the model after an edge.
  task automatic check_all(input string tag);
    logic [W-1:0]  e_grant;
    logic [IW-1:0] e_idx;
    e_grant = exp_q.pop_front();
    e_idx   = (m_holder < 0) ? '0 : IW'(m_holder);
    check_vec({tag, ".grant"}, grant_o, e_grant);
    check_bit({tag, ".val"}, grant_val_o, m_holder >= 0);
    check_vec({tag, ".idx"}, W'(grant_idx_o), W'(e_idx));
    check_bit({tag, ".timeout"}, timeout_o, m_tmo);
    check_bit({tag, ".state"}, state_o == GRANT, m_holder >= 0);
  endtask

  // ---------------- driver tasks ----------------
  // Drive inputs, take one edge, update the model, check 1 time unit later.
  task automatic step(input string tag, input logic [W-1:0] req, input logic done);
    req_i  = req;
    done_i = done;
    @(posedge clk_i);
    model_edge(req, done);
    exp_q.push_back((m_holder < 0) ? W'(0) : W'(1) << m_holder);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    req_i  = '0;
    done_i = 1'b0;
    arst_i = 1'b1;
    @(posedge clk_i);
    #1;
    arst_i = 1'b0;
    model_reset();
    exp_q.push_back('0);
    check_all("reset");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int tmo_seen;
    int grant_cycles;
    logic [W-1:0] seq_seen[$];
    logic [W-1:0] r;

    do_reset();

    // First arbitration after reset, then release by done.
    step("single_req", 5'b00100, 1'b0);
    check_vec("single_grant", grant_o, 5'b00100);
    check_vec("single_idx", W'(grant_idx_o), W'(2));
    step("single_done", 5'b00100, 1'b1);
    check_vec("single_released", grant_o, 5'b00000);
    // ptr is now 3: 00101 must pick bit 0 after wrapping past 3 and 4.
    step("ptr3_probe", 5'b00101, 1'b0);
    check_vec("ptr3_wrap", grant_o, 5'b00001);
    step("ptr3_done", 5'b00101, 1'b1);
    step("idle_gap", 5'b00000, 1'b0);
    step("idle_done_ignored", 5'b00000, 1'b1);
    check_vec("idle_zero", grant_o, 5'b00000);

    // All requesting, done pulsed in every grant cycle: full rotation.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step("rotate", 5'b11111, (m_holder >= 0));
      seq_seen.push_back(grant_o);
    end
    check_vec("rot0", seq_seen[0], 5'b00001);
    check_vec("rot1", seq_seen[1], 5'b00000);
    check_vec("rot2", seq_seen[2], 5'b00010);
    check_vec("rot4", seq_seen[4], 5'b00100);
    check_vec("rot6", seq_seen[6], 5'b01000);
    check_vec("rot8", seq_seen[8], 5'b10000);
    check_vec("rot10", seq_seen[10], 5'b00001);
    step("rot_end", 5'b00000, 1'b0);

    // Wrap-around: grant 3, release, then 01001 goes to bit 0.
    do_reset();
    step("to3_a", 5'b01000, 1'b0);
    step("to3_b", 5'b01000, 1'b1);
    step("wrap", 5'b01001, 1'b0);
    check_vec("wrap_grant", grant_o, 5'b00001);
    step("wrap_rel", 5'b00000, 1'b0);

    // Hold limit: 00010 held with no done.
    do_reset();
    grant_cycles = 0;
    tmo_seen = 0;
    step("tmo_first", 5'b00010, 1'b0);
    while (grant_o == 5'b00010 && grant_cycles < 20) begin
      grant_cycles++;
      step("tmo_hold", 5'b00010, 1'b0);
    end
    check_vec("tmo_len", W'(grant_cycles), W'(MH));
    check_bit("tmo_pulse", timeout_o, 1'b1);
    check_vec("tmo_gap", grant_o, 5'b00000);
    step("tmo_regrant", 5'b00010, 1'b0);
    check_vec("tmo_regrant_v", grant_o, 5'b00010);
    check_bit("tmo_one_cycle", timeout_o, 1'b0);

    // Holder drops its request, while a non-holder toggles.
    step("drop_other", 5'b00110, 1'b0);
    check_vec("drop_other_hold", grant_o, 5'b00010);
    step("drop", 5'b00100, 1'b0);
    check_vec("drop_zero", grant_o, 5'b00000);
    check_bit("drop_no_tmo", timeout_o, 1'b0);
    step("drop_idle", 5'b00000, 1'b0);

    // Asynchronous reset in the middle of a grant to bit 3.
    do_reset();
    step("ar_a", 5'b01000, 1'b0);
    step("ar_b", 5'b01000, 1'b0);
    check_vec("ar_granted", grant_o, 5'b01000);
    #2;
    arst_i = 1'b1;
    #1;
    check_vec("ar_async_grant", grant_o, 5'b00000);
    check_bit("ar_async_val", grant_val_o, 1'b0);
    @(posedge clk_i);
    #1;
    arst_i = 1'b0;
    model_reset();
    step("ar_rearb", 5'b11000, 1'b0);
    check_vec("ar_rearb_grant", grant_o, 5'b01000);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = W'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) r = '0;
      step("rand", r, ($urandom_range(0, 4) == 0));
      if (m_tmo) tmo_seen++;
    end
    // Long holds to force timeouts under random done-free stretches.
    for (int j = 0; j < 3; j++) begin
      r = W'($urandom_range(1, 31));
      for (int i = 0; i < 20; i++) step("rand_hold", r, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
